prism_sched: RTL
================

PRISM_SCHED -- requirements
Module: prism_sched

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of push requesters; PTW, default 16, priority width; MTW, default 32, metadata width; CAP, default 1024, PIFO capacity in entries; CNTW, default 11, occupancy counter width (holds 0..CAP); POP_BURST, default 4, maximum consecutive pop grants while a push waits; MAX_OUTST, default 8, maximum pops awaiting result.
REQ-002 i_clk  in  1  the single clock; all state on its rising edge.
REQ-003 i_arst  in  1  asynchronous, active-high reset.
REQ-004 i_push_req  in  NREQ  per-requester push request.
REQ-005 i_push_data  in  NREQ*(MTW+PTW)  requester k's entry in slice k; priority in the low PTW bits.
REQ-006 o_push_gnt  out  NREQ  one-hot push grant, combinational.
REQ-007 i_pop_req  in  1  pop request.
REQ-008 o_pop_gnt  out  1  pop grant, combinational.
REQ-009 o_pifo_push, o_pifo_pop  out  1 each  registered issue strobes to the PIFO.
REQ-010 o_pifo_data  out  MTW+PTW  registered push entry.
REQ-011 i_pifo_res_valid, i_pifo_res_data  in  1, MTW+PTW  pop result from the PIFO.
REQ-012 o_rsp_valid, o_rsp_data  out  1, MTW+PTW  registered pop result to the consumer (no backpressure).
REQ-013 o_count  out  CNTW  issued occupancy; o_full, o_empty  out  1 each.
REQ-014 o_err  out  1  sticky protocol error flag.

Function
REQ-015 A transfer SHALL occur in a cycle where req and gnt are both high; at most one grant (push or pop) SHALL be high per cycle.
REQ-016 Push eligibility SHALL be: any i_push_req, count<CAP. Pop eligibility SHALL be: i_pop_req, count>0, outstanding<MAX_OUTST.
REQ-017 FSM state S_NORM: pop is granted when pop-eligible; otherwise a push is granted when push-eligible.
REQ-018 In S_NORM, every pop grant while any i_push_req is high SHALL increment burst counter bcnt; bcnt SHALL clear on any push grant or in any cycle with no i_push_req.
REQ-019 When bcnt reaches POP_BURST the FSM SHALL move to S_FORCE; in S_FORCE push has priority over pop; after one push grant the FSM SHALL return to S_NORM with bcnt=0; in S_FORCE, if not push-eligible (full), the FSM SHALL return to S_NORM.
REQ-020 Push winner SHALL be round-robin: search starts at index last+1 mod NREQ; last updates only on push grant.
REQ-021 A granted push SHALL produce o_pifo_push=1 and o_pifo_data=granted slice on the next cycle (latency 1); a granted pop SHALL produce o_pifo_pop=1 next cycle; the strobes are single-cycle pulses, never both high.
REQ-022 o_count SHALL update on the same edge that registers the strobe: +1 on push, -1 on pop; o_full=(count==CAP); o_empty=(count==0); both are registered.
REQ-023 Outstanding counter SHALL increment on pop issue, decrement on i_pifo_res_valid; simultaneous events leave it unchanged.
REQ-024 i_pifo_res_valid SHALL be forwarded to o_rsp_valid/o_rsp_data one cycle later unchanged.
REQ-025 i_pifo_res_valid while outstanding==0 SHALL set o_err (response still forwarded, counter stays 0); o_err clears only on reset.
REQ-026 With no eligible request, all grants and issue strobes SHALL be 0 and state unchanged.

Reset
REQ-027 i_arst high SHALL immediately clear all registers regardless of clock: strobes, o_rsp_valid, o_err = 0; o_count=0; o_empty=1; o_full=0; FSM=S_NORM; bcnt=0; outstanding=0; RR pointer last=NREQ-1 (requester 0 first).
REQ-028 While i_arst is high all grants SHALL be 0; an in-flight issue or response is discarded; operation resumes on the first edge after deassertion.

Verification
REQ-029 After reset, push req on 0 and 2 each cycle, no pop -> grants 0,2,0,2; o_pifo_push one cycle after each grant; o_count 1,2,3,4.
REQ-030 CAP=4, four pushes then push req held -> o_full=1, o_push_gnt=0; one pop issued -> o_count=3, next push granted.
REQ-031 count=10, pop and push req held continuously, POP_BURST=4 -> grant pattern pop,pop,pop,pop,push repeating.
REQ-032 Empty, pop req -> o_pop_gnt=0; MAX_OUTST=2 with results withheld -> third pop blocked until one i_pifo_res_valid.
REQ-033 i_pifo_res_valid with no outstanding pop -> o_rsp_valid next cycle, o_err=1 and sticky.
REQ-034 i_arst pulsed mid-burst with count=5 -> o_count=0, strobes 0 asynchronously; after release push req 1 granted first.

Source files
------------

// File: rtl/prism_sched.sv
// Push/pop arbiter in front of a PIFO: round-robin push selection, pop-first arbitration
// with a bounded pop burst, occupancy and outstanding-pop tracking, response forwarding.
module prism_sched #(
    parameter int NREQ      = 4,
    parameter int PTW       = 16,
    parameter int MTW       = 32,
    parameter int CAP       = 1024,
    parameter int CNTW      = 11,
    parameter int POP_BURST = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    input  logic [NREQ-1:0]            i_push_req,
    input  logic [NREQ*(MTW+PTW)-1:0]  i_push_data,
    output logic [NREQ-1:0]            o_push_gnt,
    input  logic                       i_pop_req,
    output logic                       o_pop_gnt,
    output logic                       o_pifo_push,
    output logic                       o_pifo_pop,
    output logic [MTW+PTW-1:0]         o_pifo_data,
    input  logic                       i_pifo_res_valid,
    input  logic [MTW+PTW-1:0]         i_pifo_res_data,
    output logic                       o_rsp_valid,
    output logic [MTW+PTW-1:0]         o_rsp_data,
    output logic [CNTW-1:0]            o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_err,
    output logic                       o_state
);
    // Handshake: a transfer happens in any cycle where req and gnt are both high; grants
    // are combinational from current requests and registered state, at most one per cycle.
    localparam int EW = MTW + PTW;
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int BW = $clog2(POP_BURST + 1);

    typedef enum logic {S_NORM = 1'b0, S_FORCE = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   bcnt, bcnt_nxt;
    logic [LW-1:0]   last, pick;
    logic [OW-1:0]   outst;
    logic [NREQ-1:0] mask, hi;
    logic [EW-1:0]   pick_data;
    logic [CNTW-1:0] count_nxt;
    logic            push_elig, pop_elig, push_win, res_dec;

    assign o_state = state;

    // Round-robin: prefer requesters above the last winner, else wrap to the lowest index.
    always_comb begin
        mask      = '0;
        pick      = '0;
        pick_data = '0;
        for (int k = 0; k < NREQ; k++) mask[k] = (k > int'(last));
        hi = i_push_req & mask;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if ((|hi) ? hi[k] : i_push_req[k]) pick = LW'(k);
        end
        for (int k = 0; k < NREQ; k++) begin
            if (LW'(k) == pick) pick_data = i_push_data[k*EW +: EW];
        end
    end

    assign push_elig = (|i_push_req) && (o_count < CNTW'(CAP)) && !i_arst;
    assign pop_elig  = i_pop_req && (o_count != '0) && (outst < OW'(MAX_OUTST)) && !i_arst;
    assign res_dec   = i_pifo_res_valid && (outst != '0);

    always_comb begin
        o_push_gnt = '0;
        o_pop_gnt  = 1'b0;
        push_win   = 1'b0;
        state_nxt  = state;
        bcnt_nxt   = bcnt;
        case (state)
            S_NORM: begin
                if (pop_elig)       o_pop_gnt = 1'b1;
                else if (push_elig) push_win  = 1'b1;
                if (push_win || !(|i_push_req)) bcnt_nxt = '0;
                else if (o_pop_gnt)             bcnt_nxt = bcnt + 1'b1;
                if (bcnt_nxt == BW'(POP_BURST)) state_nxt = S_FORCE;
            end
            S_FORCE: begin
                if (push_elig)     push_win  = 1'b1;
                else if (pop_elig) o_pop_gnt = 1'b1;
                // Waiting pushers that cannot be served must not starve pops.
                if (push_win || pop_elig) begin
                    state_nxt = S_NORM;
                    bcnt_nxt  = '0;
                end
            end
            default: state_nxt = S_NORM;
        endcase
        if (push_win) o_push_gnt[pick] = 1'b1;
    end

    always_comb begin
        count_nxt = o_count;
        if (push_win)       count_nxt = o_count + 1'b1;
        else if (o_pop_gnt) count_nxt = o_count - 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state       <= S_NORM;
            bcnt        <= '0;
            last        <= LW'(NREQ - 1);
            outst       <= '0;
            o_pifo_push <= 1'b0;
            o_pifo_pop  <= 1'b0;
            o_pifo_data <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_count     <= '0;
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_err       <= 1'b0;
        end else begin
            state       <= state_nxt;
            bcnt        <= bcnt_nxt;
            o_pifo_push <= push_win;
            o_pifo_pop  <= o_pop_gnt;
            if (push_win) begin
                o_pifo_data <= pick_data;
                last        <= pick;
            end
            o_count <= count_nxt;
            o_full  <= (count_nxt == CNTW'(CAP));
            o_empty <= (count_nxt == '0);
            if (o_pop_gnt && !res_dec)      outst <= outst + 1'b1;
            else if (!o_pop_gnt && res_dec) outst <= outst - 1'b1;
            // A result with nothing outstanding is still forwarded but flagged.
            if (i_pifo_res_valid && (outst == '0)) o_err <= 1'b1;
            o_rsp_valid <= i_pifo_res_valid;
            o_rsp_data  <= i_pifo_res_data;
        end
    end
endmodule
